// File: rtl/adc_interface_ad7367_burst.sv
// Burst-capable controller for dual-channel simultaneous-sampling SAR ADCs.
// Handles CNVST/BUSY handshake, serial readout of both channels and sample bursts.
module adc_interface_ad7367_burst #(
  parameter int NBIT       = 14,
  parameter int CLK_DIV    = 2,
  parameter int T_CNVST    = 2,
  parameter int T_BUSY_MIN = 4,
  parameter int BUSY_TMO   = 255,
  parameter int T_QUIET    = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BUSY,
  output logic             SCLK,
  output logic             CNVST,
  output logic             CS,
  input  logic             DOUTA,
  input  logic             DOUTB,
  input  logic             cs,
  input  logic [3:0]       op,
  input  logic [7:0]       addr,
  input  logic [CNT_W-1:0] nsamples,
  output logic             rdy,
  output logic [2:0]       state,
  output logic [NBIT-1:0]  data_a,
  output logic [NBIT-1:0]  data_b,
  output logic [NBIT-1:0]  data_out,
  output logic             valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             err_timeout
);

  localparam int TW = 16;
  localparam int BW = $clog2(NBIT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CNV_START = 3'd1,
    CNV_WAIT  = 3'd2,
    READ      = 3'd3,
    QUIET     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              cnvst_q, cnvst_d;
  logic [NBIT-1:0]   sh_a_q, sh_a_d;
  logic [NBIT-1:0]   sh_b_q, sh_b_d;
  logic [NBIT-1:0]   da_q, da_d;
  logic [NBIT-1:0]   db_q, db_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nsmp_q, nsmp_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              mode_q, mode_d;
  logic              sel_q, sel_d;
  logic              rdy_q, rdy_d;
  logic              addr_unused;

  assign addr_unused = ^addr[7:1];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    cnvst_d = cnvst_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    da_d    = da_q;
    db_d    = db_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    nsmp_d  = nsmp_q;
    err_d   = err_q;
    abort_d = abort_q;
    mode_d  = mode_q;
    sel_d   = sel_q;

    if (cs) sel_d = addr[0];
    if (cs && op[3] && state_q != IDLE) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cs && op[1] && !op[3]) begin
          mode_d  = op[2];
          nsmp_d  = nsamples;
          cnt_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          cnvst_d = 1'b0;
          timer_d = '0;
          state_d = CNV_START;
        end
      end
      CNV_START: begin
        if (timer_q == TW'(T_CNVST - 1)) begin
          cnvst_d = 1'b1;
          timer_d = '0;
          state_d = CNV_WAIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      CNV_WAIT: begin
        if (timer_q >= TW'(T_BUSY_MIN) && !BUSY) begin
          cs_n_d  = 1'b0;
          timer_d = '0;
          bit_d   = '0;
          state_d = READ;
        end else if (timer_q == TW'(BUSY_TMO) && BUSY) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = QUIET;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      READ: begin
        if (timer_q == TW'(CLK_DIV - 1)) begin
          timer_d = '0;
          if (sclk_q) begin
            // the ADC word is captured on the edge that drops SCLK
            sclk_d = 1'b0;
            sh_a_d = {sh_a_q[NBIT-2:0], DOUTA};
            sh_b_d = {sh_b_q[NBIT-2:0], DOUTB};
            bit_d  = bit_q + BW'(1);
          end else if (bit_q == BW'(NBIT)) begin
            sclk_d  = 1'b1;
            cs_n_d  = 1'b1;
            da_d    = sh_a_q;
            db_d    = sh_b_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = QUIET;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      QUIET: begin
        if (timer_q == TW'(T_QUIET - 1)) begin
          timer_d = '0;
          if (!mode_q || abort_q || err_q ||
              (nsmp_q != '0 && cnt_q == nsmp_q)) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnvst_d = 1'b0;
            state_d = CNV_START;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);

    if (cs && op[0]) begin
      state_d = IDLE;
      timer_d = '0;
      bit_d   = '0;
      sclk_d  = 1'b1;
      cs_n_d  = 1'b1;
      cnvst_d = 1'b1;
      da_d    = '0;
      db_d    = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b0;
      abort_d = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      cnvst_q <= 1'b1;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      da_q    <= '0;
      db_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      nsmp_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      cnvst_q <= cnvst_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      da_q    <= da_d;
      db_q    <= db_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      nsmp_q  <= nsmp_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
    end
  end

  assign SCLK        = sclk_q;
  assign CS          = cs_n_q;
  assign CNVST       = cnvst_q;
  assign rdy         = rdy_q;
  assign state       = state_q;
  assign data_a      = da_q;
  assign data_b      = db_q;
  assign data_out    = sel_q ? db_q : da_q;
  assign valid       = valid_q;
  assign sample_cnt  = cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_adc_interface_ad7367_burst.sv
// Directed bench for adc_interface_ad7367_burst: default and 12-bit/fast-SCLK
// instances, each driven by a small ADC pin model.
module tb_adc_interface_ad7367_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        BUSY = 1'b0;
  bit          busy_stuck = 1'b0;
  logic        SCLK, CNVST, CS, DOUTA, DOUTB;
  logic        cs = 1'b0;
  logic [3:0]  op = '0;
  logic [7:0]  addr = '0;
  logic [15:0] nsamples = '0;
  logic        rdy, valid, err_timeout;
  logic [2:0]  state;
  logic [13:0] data_a, data_b, data_out;
  logic [15:0] sample_cnt;

  logic        SCLK2, CNVST2, CS2, DOUTA2, DOUTB2;
  logic        cs2 = 1'b0;
  logic [3:0]  op2 = '0;
  logic [7:0]  addr2 = '0;
  logic [15:0] nsamples2 = '0;
  logic        rdy2, valid2, err2;
  logic [2:0]  state2;
  logic [11:0] data_a2, data_b2, data_out2;
  logic [15:0] sample_cnt2;

  logic [13:0] wa = 14'h2AAA;
  logic [13:0] wb = 14'h1555;
  logic [11:0] wa2 = 12'hA5C;
  logic [11:0] wb2 = 12'h3C9;
  int fa = 0;
  int fa2 = 0;

  int checks = 0;
  int failures = 0;

  int vcnt = 0, sfall = 0, cnvlo = 0, cslo = 0;
  int hi_run = 0, min_hi = 1000;
  int vcnt2 = 0, sfall2 = 0, cslo2 = 0, sclklo2 = 0;

  adc_interface_ad7367_burst dut (
    .clk(clk), .rst_n(rst_n), .BUSY(BUSY),
    .SCLK(SCLK), .CNVST(CNVST), .CS(CS),
    .DOUTA(DOUTA), .DOUTB(DOUTB),
    .cs(cs), .op(op), .addr(addr), .nsamples(nsamples),
    .rdy(rdy), .state(state),
    .data_a(data_a), .data_b(data_b), .data_out(data_out),
    .valid(valid), .sample_cnt(sample_cnt),
    .err_timeout(err_timeout)
  );

  adc_interface_ad7367_burst #(.NBIT(12), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .BUSY(1'b0),
    .SCLK(SCLK2), .CNVST(CNVST2), .CS(CS2),
    .DOUTA(DOUTA2), .DOUTB(DOUTB2),
    .cs(cs2), .op(op2), .addr(addr2), .nsamples(nsamples2),
    .rdy(rdy2), .state(state2),
    .data_a(data_a2), .data_b(data_b2), .data_out(data_out2),
    .valid(valid2), .sample_cnt(sample_cnt2),
    .err_timeout(err2)
  );

  always #5 clk = ~clk;

  // ADC pin models: bit index restarts on CS fall, advances on SCLK fall
  always @(negedge CS or negedge SCLK) begin
    if (!CS && SCLK) fa <= 0;
    else if (!CS) fa <= fa + 1;
  end
  assign DOUTA = (fa < 14) ? wa[13 - fa] : 1'b0;
  assign DOUTB = (fa < 14) ? wb[13 - fa] : 1'b0;

  always @(negedge CS2 or negedge SCLK2) begin
    if (!CS2 && SCLK2) fa2 <= 0;
    else if (!CS2) fa2 <= fa2 + 1;
  end
  assign DOUTA2 = (fa2 < 12) ? wa2[11 - fa2] : 1'b0;
  assign DOUTB2 = (fa2 < 12) ? wb2[11 - fa2] : 1'b0;

  always @(posedge CNVST) begin
    #1 BUSY = 1'b1;
    repeat (10) @(posedge clk);
    #1 BUSY = busy_stuck;
  end

  always @(posedge clk) begin
    if (valid) vcnt++;
    if (!CNVST) cnvlo++;
    if (!CS) cslo++;
    if (CS) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
    if (valid2) vcnt2++;
    if (!CS2) cslo2++;
    if (!SCLK2) sclklo2++;
  end
  always @(negedge SCLK) sfall++;
  always @(negedge SCLK2) sfall2++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] o, input logic [7:0] a,
                     input logic [15:0] n);
    cs = 1'b1; op = o; addr = a; nsamples = n;
    @(posedge clk); #1;
    cs = 1'b0; op = '0;
  endtask

  task automatic cmd2(input logic [3:0] o, input logic [7:0] a);
    cs2 = 1'b1; op2 = o; addr2 = a; nsamples2 = '0;
    @(posedge clk); #1;
    cs2 = 1'b0; op2 = '0;
  endtask

  task automatic wait_st(input bit i2, input logic [2:0] s,
                         input int maxc, input string tag);
    int n = 0;
    while (((i2 ? state2 : state) !== s) && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, i2 ? state2 : state, s);
  endtask

  task automatic wait_sclk_low(input string tag);
    int n = 0;
    while (SCLK !== 1'b0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, SCLK, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, s0, c0, l0;
    int n;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_sclk", SCLK, 1);
    chk("rst_cs", CS, 1);
    chk("rst_cnvst", CNVST, 1);
    chk("rst_rdy", rdy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_data_a", data_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", rdy, 1);
    repeat (20) @(posedge clk);
    #1;

    // single conversion
    v0 = vcnt; s0 = sfall; c0 = cnvlo; l0 = cslo;
    cmd(4'b0010, 8'h00, 16'd0);
    chk("single_rdy_low", rdy, 0);
    wait_st(0, 3'd0, 300, "single_idle");
    chk("single_rdy", rdy, 1);
    chk("single_data_a", data_a, 14'h2AAA);
    chk("single_data_b", data_b, 14'h1555);
    chk("single_data_out", data_out, 14'h2AAA);
    chk("single_valids", vcnt - v0, 1);
    chk("single_cnt", sample_cnt, 1);
    chk("single_sclk_falls", sfall - s0, 14);
    chk("single_cnvst_low", cnvlo - c0, 2);
    chk("single_cs_low", cslo - l0, 56);

    // burst of three
    v0 = vcnt; s0 = sfall;
    cmd(4'b0110, 8'h00, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    wait_st(0, 3'd0, 1000, "burst_idle");
    chk("burst_valids", vcnt - v0, 3);
    chk("burst_cnt", sample_cnt, 3);
    chk("burst_sclk_falls", sfall - s0, 42);
    chk("burst_quiet_ok", (min_hi >= 3) ? 1 : 0, 1);

    // free-run, abort during the fifth READ
    v0 = vcnt;
    cmd(4'b0110, 8'h00, 16'd0);
    n = 0;
    while ((vcnt - v0) < 4 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("free_four", vcnt - v0, 4);
    wait_st(0, 3'd3, 200, "free_fifth_read");
    cmd(4'b1000, 8'h00, 16'd0);
    chk("abort_not_idle", state, 3);
    wait_st(0, 3'd0, 300, "abort_idle");
    repeat (50) @(posedge clk);
    #1;
    chk("abort_valids", vcnt - v0, 5);
    chk("abort_cnt", sample_cnt, 5);
    chk("abort_stays_idle", state, 0);

    // BUSY stuck high
    busy_stuck = 1'b1;
    v0 = vcnt;
    cmd(4'b0010, 8'h00, 16'd0);
    chk("tmo_cnt_clr", sample_cnt, 0);
    repeat (257) @(posedge clk);
    #1;
    chk("tmo_err_before", err_timeout, 0);
    chk("tmo_still_wait", state, 2);
    @(posedge clk); #1;
    chk("tmo_err_at", err_timeout, 1);
    chk("tmo_quiet", state, 4);
    wait_st(0, 3'd0, 20, "tmo_idle");
    chk("tmo_valids", vcnt - v0, 0);
    chk("tmo_rdy", rdy, 1);
    busy_stuck = 1'b0;
    cmd(4'b0010, 8'h00, 16'd0);
    chk("tmo_err_cleared", err_timeout, 0);
    wait_st(0, 3'd0, 300, "tmo_recover_idle");
    chk("tmo_recover_valids", vcnt - v0, 1);
    chk("tmo_recover_data", data_b, 14'h1555);

    // async reset during READ
    cmd(4'b0010, 8'h00, 16'd0);
    wait_st(0, 3'd3, 200, "arst_read");
    wait_sclk_low("arst_sclk_low");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sclk", SCLK, 1);
    chk("arst_cs", CS, 1);
    chk("arst_cnvst", CNVST, 1);
    chk("arst_state", state, 0);
    chk("arst_data_a", data_a, 0);
    chk("arst_cnt", sample_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_rdy_back", rdy, 1);

    // soft reset during READ
    cmd(4'b0010, 8'h00, 16'd0);
    wait_st(0, 3'd3, 200, "srst_read");
    wait_sclk_low("srst_sclk_low");
    chk("srst_cs_low", CS, 0);
    cmd(4'b0001, 8'h00, 16'd0);
    chk("srst_state", state, 0);
    chk("srst_cs", CS, 1);
    chk("srst_sclk", SCLK, 1);
    chk("srst_rdy", rdy, 0);
    @(posedge clk); #1;
    chk("srst_rdy_back", rdy, 1);

    // channel mux on the default instance
    cmd(4'b0010, 8'h01, 16'd0);
    wait_st(0, 3'd0, 300, "mux_idle");
    chk("mux_b", data_out, 14'h1555);

    // 12-bit, CLK_DIV=1 instance
    v0 = vcnt2; s0 = sfall2; c0 = sclklo2; l0 = cslo2;
    cmd2(4'b0010, 8'h01);
    wait_st(1, 3'd0, 200, "p12_idle");
    chk("p12_data_out_b", data_out2, 12'h3C9);
    chk("p12_data_a", data_a2, 12'hA5C);
    chk("p12_valids", vcnt2 - v0, 1);
    chk("p12_sclk_falls", sfall2 - s0, 12);
    chk("p12_sclk_low", sclklo2 - c0, 12);
    chk("p12_cs_low", cslo2 - l0, 24);
    cmd2(4'b0000, 8'h00);
    chk("p12_data_out_a", data_out2, 12'hA5C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
